irom_loader: RTL

Boot-time sequencer that owns the core's setup phase. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into the instruction ROM at consecutive word addresses from 0, holding the core in setup mode until the image is complete. It sits between the external boot/debug byte port and the IROM write port, and it drives the `setup` input of the instruction decoder.

---
 rtl/irom_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/irom_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them into the IROM from address 0.
// Optional build macro IROM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check (CHK state).
module irom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              setup,
    output logic              irom_we,
    output logic [ADDR_W-1:0] irom_addr,
    output logic [31:0]       irom_wdata,
    output logic              done,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // LEN   | shifting in the 4-byte word count
    // DATA  | shifting in the 4 bytes of the next word
    // WRITE | one-cycle IROM write of the assembled word
    // CHK   | shifting in the 4-byte checksum (macro builds only)
    // DONE  | image loaded, done held high
    // ERR   | load aborted, err held high
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
`ifdef IROM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd4;
`endif
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]      state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [ADDR_W:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [31:0]     len_q, len_d, len_next;
    logic [31:0]     word_q, word_d, word_next;
    logic            setup_q, setup_d;
    logic            we_q, we_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            byte_acc;
    logic [2:0]      end_state;
`ifdef IROM_LOADER_CHECKSUM_EN
    logic [31:0]     sum_q, sum_d;
`endif

    always_comb begin
        byte_ready = (state_q == S_LEN) || (state_q == S_DATA);
`ifdef IROM_LOADER_CHECKSUM_EN
        byte_ready = byte_ready || (state_q == S_CHK);
        end_state  = S_CHK;
`else
        end_state  = S_DONE;
`endif
    end

    assign byte_acc  = byte_valid & byte_ready;
    assign len_next  = {byte_data, len_q[31:8]};
    assign word_next = {byte_data, word_q[31:8]};
    assign wcnt_inc  = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        word_d  = word_q;
`ifdef IROM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    bcnt_d  = 2'd0;
                    wcnt_d  = '0;
                    len_d   = 32'd0;
`ifdef IROM_LOADER_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                end
            end
            S_LEN: begin
                if (byte_acc) begin
                    len_d  = len_next;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (len_next == 32'd0)
                            state_d = end_state;
                        else if (len_next > 32'(DEPTH))
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_acc) begin
                    word_d = word_next;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wcnt_d = wcnt_inc;
`ifdef IROM_LOADER_CHECKSUM_EN
                sum_d  = sum_q + word_q;
`endif
                if (32'(wcnt_inc) == len_q)
                    state_d = end_state;
                else
                    state_d = S_DATA;
            end
`ifdef IROM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (byte_acc) begin
                    word_d = word_next;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3)
                        state_d = (word_next == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        setup_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
`ifdef IROM_LOADER_CHECKSUM_EN
        setup_d = setup_d || (state_d == S_CHK);
`endif
        we_d    = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bcnt_q  <= 2'd0;
            wcnt_q  <= '0;
            len_q   <= 32'd0;
            word_q  <= 32'd0;
            setup_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IROM_LOADER_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
            setup_q <= setup_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IROM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign setup      = setup_q;
    assign irom_we    = we_q;
    assign irom_addr  = wcnt_q[ADDR_W-1:0];
    assign irom_wdata = word_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
